// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory stage of the 5-stage ARM pipeline, fed by the EXE/MEM register.
//   Holds a word-addressed data memory mapped at BASE_ADDR. Loads are returned
//   combinationally to the MEM/WB register; stores commit on the clock edge
//   that completes the access.
//
//   Optional feature macro: MEM_WAIT_STATES_EN
//     When defined, an IDLE/BUSY/DONE FSM with a 4-bit wait counter holds
//     ready low for WAIT_CYCLES cycles per access, which freezes the
//     upstream pipeline registers. When undefined, every access completes
//     in a single cycle and ready is constantly 1.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset
//   MEM_R_EN  in   1      load request
//   MEM_W_EN  in   1      store request (wins over a simultaneous load)
//   ALU_Res   in   WIDTH  byte address
//   Val_Rm    in   WIDTH  store data
//   mem_data  out  WIDTH  load data to the MEM/WB register
//   ready     out  1      access complete this cycle; 1 when idle
//   freeze    out  1      ~ready; stalls IF..EXE/MEM registers
//   addr_err  out  1      current request lies outside the mapped window
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_LOG2  = 6,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [WIDTH-1:0] ALU_Res,
    input  logic [WIDTH-1:0] Val_Rm,
    output logic [WIDTH-1:0] mem_data,
    output logic             ready,
    output logic             freeze,
    output logic             addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      off;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic                  inRange;
    logic                  req;
    logic                  isLoad;
    logic                  accessDone;
    logic                  readyInt;
    logic                  commit;
    logic                  unusedBits;

    // The subtraction wraps, so addresses below BASE_ADDR become huge offsets
    // and fall out of range through the same upper-bits test.
    assign off        = ALU_Res - WIDTH'(BASE_ADDR);
    assign wordIdx    = off[DEPTH_LOG2+1:2];
    assign inRange    = (off >> (DEPTH_LOG2 + 2)) == '0;
    assign req        = MEM_R_EN | MEM_W_EN;
    assign isLoad     = MEM_R_EN & ~MEM_W_EN;
    assign addr_err   = req & ~inRange;
    assign unusedBits = ^{off[1:0], WAIT_CYCLES[0]};

`ifdef MEM_WAIT_STATES_EN
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY     = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Wait-state sequencing. The request cycle in IDLE already counts as the
    // first wait state, which is why the counter is preloaded with
    // WAIT_CYCLES-1 and BUSY exits once it reaches 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readyInt   = 1'b1;
        accessDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CNT == 4'd0) begin
                        accessDone = 1'b1;
                    end else begin
                        readyInt = 1'b0;
                        cnt_d    = WAIT_CNT - 4'd1;
                        state_d  = (WAIT_CNT == 4'd1) ? DONE : BUSY;
                    end
                end
            end
            BUSY: begin
                readyInt = 1'b0;
                cnt_d    = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                accessDone = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign accessDone = 1'b1;
    assign readyInt   = 1'b1;
`endif

    // Out-of-range stores are dropped instead of aliasing onto a real word.
    assign commit = MEM_W_EN & inRange & accessDone;

    // Reset clears the whole array in one cycle and takes priority over any
    // pending store, so an access aborted by reset never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[wordIdx] <= Val_Rm;
        end
    end

    // Outputs are forced to their idle values while reset is held so the
    // pipeline sees a clean stage even if stale request inputs linger.
    always_comb begin
        mem_data = '0;
        if (!rst && isLoad && inRange) begin
            mem_data = mem_q[wordIdx];
        end
    end

    assign ready  = rst | readyInt;
    assign freeze = ~ready;

endmodule
